// File: rtl/apb_pkg.sv
// Shared APB definitions.
//   state_t : slave FSM states (IDLE, ACCESS)
//   pmode_t : master-side transfer mode encodings (NOP, READ, WRITE)
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    READ  = 2'b10,
    WRITE = 2'b11
  } pmode_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// Register array for the APB slave: one synchronous write port and one
// asynchronous read mux sharing a single address.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears all regs)
//   we, addr, wdata : write strobe / register index / write data
//   rdata           : contents of reg[addr] (raw, gated by the caller)
module apb_slave_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_DEPTH  = 16,
  parameter int IDX_W      = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [REG_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Caller only uses rdata when addr is in range.
  assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave.sv
// APB slave with a small register file.
// Two-state FSM (IDLE/ACCESS) captures address and direction in the setup
// phase; the transfer completes in ACCESS once PREADY_o is high.
// Optional wait states are enabled with the macro APB_SLAVE_WAIT_EN; without
// it the wait counter is a constant 0 and every transfer takes 2 cycles.
// Ports:
//   PCLK_i, PRESET_i              : clock, synchronous active-high reset
//   PSEL_i, PENABLE_i, PWRITE_i   : APB control
//   PADDR_i, PWDATA_i             : address, write data
//   PRDATA_o, PREADY_o, PSLVERR_o : read data, ready, error response
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int REG_DEPTH   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK_i,
  input  logic                  PRESET_i,
  input  logic                  PSEL_i,
  input  logic                  PENABLE_i,
  input  logic                  PWRITE_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_i,
  output logic [DATA_WIDTH-1:0] PRDATA_o,
  output logic                  PREADY_o,
  output logic                  PSLVERR_o
);

  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [CW-1:0]         wait_cnt;
  logic                  ready;
  logic                  addr_err;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd;

  // Widened by one bit so REG_DEPTH == 2^ADDR_WIDTH never flags an error.
  assign addr_err = {1'b0, addr_q} >= (ADDR_WIDTH+1)'(REG_DEPTH);
  assign ready    = (state == ACCESS) && (wait_cnt == '0);
  assign commit   = ready && PSEL_i && PENABLE_i && wr_q && !addr_err;

`ifndef APB_SLAVE_WAIT_EN
  assign wait_cnt = '0;
`endif

  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      state  <= IDLE;
      addr_q <= '0;
      wr_q   <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (PSEL_i && !PENABLE_i) begin
            state  <= ACCESS;
            addr_q <= PADDR_i;
            wr_q   <= PWRITE_i;
`ifdef APB_SLAVE_WAIT_EN
            wait_cnt <= CW'(WAIT_CYCLES);
`endif
          end
        end
        ACCESS: begin
          // Deselect aborts; otherwise leave only on the completion edge.
          if (!PSEL_i || (PENABLE_i && ready)) state <= IDLE;
`ifdef APB_SLAVE_WAIT_EN
          if (wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_DEPTH  (REG_DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk   (PCLK_i),
    .rst   (PRESET_i),
    .we    (commit),
    .addr  (addr_q[IDX_W-1:0]),
    .wdata (PWDATA_i),
    .rdata (rd)
  );

  assign PREADY_o  = ready;
  assign PSLVERR_o = ready && addr_err;
  assign PRDATA_o  = (ready && !wr_q && !addr_err) ? rd : '0;

endmodule
